// File: rtl/ysyx_22050612_mem_arbiter.sv
// Two-requester memory arbiter: instruction fetch (read-only) and load/store
// share a single memory port, with one transaction in flight at a time.
//
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   if_req_*  / if_resp_*          fetch request / response handshakes
//   ls_req_*  / ls_resp_*          load/store request / response handshakes
//   mem_req_*                      registered request to memory (valid/ready)
//   mem_resp_valid, mem_resp_data  memory response pulse, no backpressure
module ysyx_22050612_mem_arbiter #(
    parameter int unsigned ADDR_W = 64,
    parameter int unsigned DATA_W = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    // fetch port
    input  logic                if_req_valid,
    output logic                if_req_ready,
    input  logic [ADDR_W-1:0]   if_req_addr,
    output logic                if_resp_valid,
    input  logic                if_resp_ready,
    output logic [DATA_W-1:0]   if_resp_data,
    // load/store port
    input  logic                ls_req_valid,
    output logic                ls_req_ready,
    input  logic [ADDR_W-1:0]   ls_req_addr,
    input  logic                ls_req_wen,
    input  logic [DATA_W-1:0]   ls_req_wdata,
    input  logic [DATA_W/8-1:0] ls_req_wmask,
    output logic                ls_resp_valid,
    input  logic                ls_resp_ready,
    output logic [DATA_W-1:0]   ls_resp_data,
    // memory port
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [ADDR_W-1:0]   mem_req_addr,
    output logic                mem_req_wen,
    output logic [DATA_W-1:0]   mem_req_wdata,
    output logic [DATA_W/8-1:0] mem_req_wmask,
    input  logic                mem_resp_valid,
    input  logic [DATA_W-1:0]   mem_resp_data
);

    localparam int unsigned MaskW = DATA_W / 8;

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

    state_e             state_q, state_d;
    logic               last_ls_q, last_ls_d;    // 1: load/store won the last grant
    logic               owner_ls_q, owner_ls_d;  // 1: current transaction belongs to LS
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic               wen_q, wen_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic [MaskW-1:0]   wmask_q, wmask_d;
    logic [DATA_W-1:0]  rdata_q, rdata_d;

    logic grant_if, grant_ls, owner_resp_ready;

    always_comb begin
        // On a tie, LS only wins if fetch won the previous grant.
        grant_ls         = ls_req_valid & (~if_req_valid | ~last_ls_q);
        grant_if         = if_req_valid & ~grant_ls;
        owner_resp_ready = owner_ls_q ? ls_resp_ready : if_resp_ready;
    end

    always_comb begin
        state_d    = state_q;
        last_ls_d  = last_ls_q;
        owner_ls_d = owner_ls_q;
        addr_d     = addr_q;
        wen_d      = wen_q;
        wdata_d    = wdata_q;
        wmask_d    = wmask_q;
        rdata_d    = rdata_q;

        unique case (state_q)
            StIdle: begin
                if (grant_ls) begin
                    addr_d     = ls_req_addr;
                    wen_d      = ls_req_wen;
                    wdata_d    = ls_req_wdata;
                    wmask_d    = ls_req_wmask;
                    owner_ls_d = 1'b1;
                    last_ls_d  = 1'b1;
                    state_d    = StIssue;
                end else if (grant_if) begin
                    addr_d     = if_req_addr;
                    wen_d      = 1'b0;
                    wdata_d    = '0;
                    wmask_d    = '0;
                    owner_ls_d = 1'b0;
                    last_ls_d  = 1'b0;
                    state_d    = StIssue;
                end
            end
            StIssue: begin
                if (mem_req_ready) state_d = StWait;
            end
            StWait: begin
                if (mem_resp_valid) begin
                    rdata_d = mem_resp_data;
                    state_d = StResp;
                end
            end
            StResp: begin
                if (owner_resp_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            last_ls_q  <= 1'b1;  // fetch wins the first tie
            owner_ls_q <= 1'b0;
            addr_q     <= '0;
            wen_q      <= 1'b0;
            wdata_q    <= '0;
            wmask_q    <= '0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            last_ls_q  <= last_ls_d;
            owner_ls_q <= owner_ls_d;
            addr_q     <= addr_d;
            wen_q      <= wen_d;
            wdata_q    <= wdata_d;
            wmask_q    <= wmask_d;
            rdata_q    <= rdata_d;
        end
    end

    always_comb begin
        if_req_ready  = (state_q == StIdle) & grant_if;
        ls_req_ready  = (state_q == StIdle) & grant_ls;
        if_resp_valid = (state_q == StResp) & ~owner_ls_q;
        ls_resp_valid = (state_q == StResp) & owner_ls_q;
        if_resp_data  = rdata_q;
        ls_resp_data  = rdata_q;
        mem_req_valid = (state_q == StIssue);
        mem_req_addr  = addr_q;
        mem_req_wen   = wen_q;
        mem_req_wdata = wdata_q;
        mem_req_wmask = wmask_q;
    end

endmodule

// File: tb/tb_ysyx_22050612_mem_arbiter.sv
module tb_ysyx_22050612_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_req_valid = 1'b0, if_req_ready, if_resp_valid, if_resp_ready = 1'b1;
    logic [63:0] if_req_addr = '0, if_resp_data;
    logic        ls_req_valid = 1'b0, ls_req_ready, ls_req_wen = 1'b0;
    logic [63:0] ls_req_addr = '0, ls_req_wdata = '0, ls_resp_data;
    logic [7:0]  ls_req_wmask = '0;
    logic        ls_resp_valid, ls_resp_ready = 1'b1;
    logic        mem_req_valid, mem_req_ready = 1'b0, mem_req_wen;
    logic [63:0] mem_req_addr, mem_req_wdata;
    logic [7:0]  mem_req_wmask;
    logic        mem_resp_valid = 1'b0;
    logic [63:0] mem_resp_data = '0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ysyx_22050612_mem_arbiter #(.ADDR_W(64), .DATA_W(64)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_req_addr(if_req_addr),
        .if_resp_valid(if_resp_valid), .if_resp_ready(if_resp_ready),
        .if_resp_data(if_resp_data),
        .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready), .ls_req_addr(ls_req_addr),
        .ls_req_wen(ls_req_wen), .ls_req_wdata(ls_req_wdata), .ls_req_wmask(ls_req_wmask),
        .ls_resp_valid(ls_resp_valid), .ls_resp_ready(ls_resp_ready),
        .ls_resp_data(ls_resp_data),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_addr(mem_req_addr), .mem_req_wen(mem_req_wen),
        .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // From ISSUE: memory accepts immediately and answers in the next cycle; ends in RESP.
    task automatic run_mem(input logic [63:0] d);
        mem_req_ready = 1'b1;
        step();
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_data  = d;
        step();
        mem_resp_valid = 1'b0;
    endtask

    initial begin
        // Reset state
        step();
        step();
        check("rst_if_req_ready", if_req_ready, 0);
        check("rst_mem_req_valid", mem_req_valid, 0);
        check("rst_resp_valid", {if_resp_valid, ls_resp_valid}, 0);
        check("rst_mem_req_addr", mem_req_addr, 0);
        rst_n = 1'b1;
        step();

        // Fetch-only read, zero-wait memory
        if_req_valid = 1'b1;
        if_req_addr  = 64'h8000_0000;
        #1;
        check("if_only_req_ready", {if_req_ready, ls_req_ready}, 2'b10);
        step();
        if_req_valid = 1'b0;
        check("if_only_issue", {mem_req_valid, mem_req_wen}, 2'b10);
        check("if_only_addr", mem_req_addr, 64'h8000_0000);
        check("if_only_wmask", mem_req_wmask, 0);
        run_mem(64'h13);
        check("if_only_resp_valid", {if_resp_valid, ls_resp_valid}, 2'b10);
        check("if_only_resp_data", if_resp_data, 64'h13);
        step();
        check("if_only_resp_done", if_resp_valid, 0);

        // LS write
        ls_req_valid = 1'b1;
        ls_req_wen   = 1'b1;
        ls_req_addr  = 64'h8000_1000;
        ls_req_wdata = 64'h1122_3344_5566_7788;
        ls_req_wmask = 8'hF0;
        #1;
        check("ls_wr_req_ready", {if_req_ready, ls_req_ready}, 2'b01);
        step();
        ls_req_valid = 1'b0;
        ls_req_wen   = 1'b0;
        check("ls_wr_mem_valid_wen", {mem_req_valid, mem_req_wen}, 2'b11);
        check("ls_wr_addr", mem_req_addr, 64'h8000_1000);
        check("ls_wr_wdata", mem_req_wdata, 64'h1122_3344_5566_7788);
        check("ls_wr_wmask", mem_req_wmask, 8'hF0);
        run_mem(64'hAAAA);
        check("ls_wr_resp_valid", {if_resp_valid, ls_resp_valid}, 2'b01);
        check("ls_wr_resp_data", ls_resp_data, 64'hAAAA);
        step();
        check("ls_wr_resp_done", ls_resp_valid, 0);

        // Both valid from reset: grants alternate IF, LS, ...
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        if_req_valid = 1'b1;
        if_req_addr  = 64'h1000;
        ls_req_valid = 1'b1;
        ls_req_addr  = 64'h2000;
        for (int i = 0; i < 6; i++) begin
            #1;
            check("alt_grant", {if_req_ready, ls_req_ready}, (i % 2 == 0) ? 2'b10 : 2'b01);
            step();
            check("alt_addr", mem_req_addr, (i % 2 == 0) ? 64'h1000 : 64'h2000);
            run_mem(64'(i + 100));
            check("alt_resp", {if_resp_valid, ls_resp_valid}, (i % 2 == 0) ? 2'b10 : 2'b01);
            check("alt_data", if_resp_data, 64'(i + 100));
            step();
        end
        if_req_valid = 1'b0;
        ls_req_valid = 1'b0;
        step();

        // Backpressure on both the memory request and the fetch response
        if_req_valid = 1'b1;
        if_req_addr  = 64'h4444;
        step();
        if_req_valid = 1'b0;
        ls_req_valid = 1'b1;
        ls_req_addr  = 64'h5555;
        for (int i = 0; i < 5; i++) begin
            check("bp_issue_hold", {mem_req_valid, ls_req_ready}, 2'b10);
            check("bp_addr_stable", mem_req_addr, 64'h4444);
            step();
        end
        run_mem(64'h9999);
        if_resp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("bp_resp_hold", {if_resp_valid, ls_req_ready}, 2'b10);
            check("bp_resp_data", if_resp_data, 64'h9999);
            step();
        end
        if_resp_ready = 1'b1;
        step();
        check("bp_ls_ready_after", ls_req_ready, 1);
        ls_req_valid = 1'b0;  // withdrawn before acceptance
        step();
        check("withdrawn_no_txn", mem_req_valid, 0);

        // Reset while waiting, then a stale response arrives
        if_req_valid = 1'b1;
        if_req_addr  = 64'h6000;
        step();
        if_req_valid  = 1'b0;
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        check("rst_wait_cleared", {mem_req_valid, if_resp_valid, ls_resp_valid}, 0);
        check("rst_wait_addr", mem_req_addr, 0);
        step();
        rst_n = 1'b1;
        mem_resp_valid = 1'b1;
        mem_resp_data  = 64'hDEAD;
        step();
        mem_resp_valid = 1'b0;
        check("late_resp_ignored", {mem_req_valid, if_resp_valid, ls_resp_valid}, 0);
        ls_req_valid = 1'b1;
        ls_req_addr  = 64'h3000;
        #1;
        check("after_rst_grant", ls_req_ready, 1);
        step();
        ls_req_valid = 1'b0;
        check("after_rst_addr", mem_req_addr, 64'h3000);
        run_mem(64'h55);
        check("after_rst_resp", {ls_resp_valid, ls_resp_data}, {1'b1, 64'h55});
        step();

        // Spurious responses in IDLE and ISSUE are ignored
        mem_resp_valid = 1'b1;
        mem_resp_data  = 64'hBAD;
        step();
        mem_resp_valid = 1'b0;
        check("spur_idle", {mem_req_valid, if_resp_valid, ls_resp_valid}, 0);
        if_req_valid = 1'b1;
        if_req_addr  = 64'h7000;
        step();
        if_req_valid   = 1'b0;
        mem_resp_valid = 1'b1;
        step();
        mem_resp_valid = 1'b0;
        check("spur_issue", {mem_req_valid, if_resp_valid}, 2'b10);
        run_mem(64'h77);
        check("spur_real_resp", {if_resp_valid, if_resp_data}, {1'b1, 64'h77});
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
